// File: rtl/mips_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_loader_pkg : loader FSM state encoding and default parameters   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package mips_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DUMP = 2'd3
  } loader_state_t;

  localparam int c_DATA_WIDTH_DEF = 32;
  localparam int c_ADDR_WIDTH_DEF = 8;
  localparam int c_NUM_CH_DEF     = 2;
  localparam int c_CYC_WIDTH_DEF  = 16;

endpackage
`default_nettype wire

// File: rtl/mips_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_rr_arbiter : round-robin one-hot arbiter, priority one above    |
// | the last grant. Revision 1.0                                         |
// +----------------------------------------------------------------------+
module mips_rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_grant
);

  localparam int c_PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [c_PW-1:0] r_ptr;
  logic [c_PW-1:0] w_next_ptr;
  logic            w_any;
  int              w_sel;
  int              w_best;
  int              w_dist;

  // Each requester is ranked by its distance above the pointer; lowest rank wins.
  always_comb begin
    w_any      = 1'b0;
    w_sel      = 0;
    w_best     = NUM_CH;
    w_dist     = 0;
    o_grant    = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_dist = ch - int'(r_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_CH;
      if (i_req[ch] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = ch;
        w_any  = 1'b1;
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      o_grant[ch] = w_any && (w_sel == ch);
    end
    w_next_ptr = (w_sel == NUM_CH - 1) ? '0 : c_PW'(w_sel + 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_prog_loader : loads a program into a MIPS core, runs it for a   |
// | set cycle count, then serves arbitrated data-memory readback.        |
// | Optional: MIPS_LOADER_CHECKSUM_EN enables the load checksum.         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEF,
  parameter int NUM_CH     = c_NUM_CH_DEF,
  parameter int CYC_WIDTH  = c_CYC_WIDTH_DEF
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         load_valid_in,
  output logic                         load_ready_out,
  input  logic [DATA_WIDTH-1:0]        load_data_in,
  input  logic                         load_last_in,
  input  logic                         start_in,
  input  logic                         restart_in,
  input  logic [CYC_WIDTH-1:0]         run_cycles_in,
  output logic                         core_reset_out,
  output logic                         instrWrite_out,
  output logic [ADDR_WIDTH-1:0]        instr_address_out,
  output logic [DATA_WIDTH-1:0]        instr_out,
  output logic [ADDR_WIDTH-1:0]        read_data_address_out,
  input  logic [DATA_WIDTH-1:0]        read_data_in,
  input  logic [NUM_CH-1:0]            rd_req_in,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr_in,
  output logic [NUM_CH-1:0]            rd_valid_out,
  output logic [DATA_WIDTH-1:0]        rd_data_out,
  output logic [1:0]                   state_out,
  output logic                         done_out,
  output logic                         overflow_out,
  output logic [CYC_WIDTH-1:0]         cycle_count_out,
  output logic [DATA_WIDTH-1:0]        checksum_out
);

  loader_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_instr_we;
  logic [ADDR_WIDTH-1:0] r_instr_addr;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [CYC_WIDTH-1:0]  r_remain;
  logic [CYC_WIDTH-1:0]  r_cycles;
  logic                  r_overflow;
  logic [NUM_CH-1:0]     r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_accept;
  logic                  w_restart;
  logic [NUM_CH-1:0]     w_req;
  logic [NUM_CH-1:0]     w_grant;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_accept  = load_valid_in && (r_state == LOAD);
  assign w_restart = restart_in && (r_state == DUMP);
  // A restart cycle issues no grant so the pointer and response path stay quiet.
  assign w_req     = rd_req_in & {NUM_CH{(r_state == DUMP) && !restart_in}};

  mips_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clock_in),
    .rst_n   (reset_in),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_comb begin
    w_rd_addr = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_grant[ch]) w_rd_addr = rd_addr_in[ch*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      r_state      <= LOAD;
      r_addr       <= '0;
      r_instr_we   <= 1'b0;
      r_instr_addr <= '0;
      r_instr      <= '0;
      r_remain     <= '0;
      r_cycles     <= '0;
      r_overflow   <= 1'b0;
      r_rd_valid   <= '0;
      r_rd_data    <= '0;
    end else begin
      r_instr_we <= 1'b0;
      r_rd_valid <= w_grant;
      if (|w_grant) r_rd_data <= read_data_in;
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_instr_we   <= 1'b1;
            r_instr      <= load_data_in;
            r_instr_addr <= r_addr;
            r_addr       <= r_addr + ADDR_WIDTH'(1);
            if (load_last_in) begin
              r_state <= WAIT;
            end else if (r_addr == {ADDR_WIDTH{1'b1}}) begin
              r_state    <= WAIT;
              r_overflow <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (start_in) begin
            if (run_cycles_in == '0) begin
              r_state <= DUMP;
            end else begin
              r_remain <= run_cycles_in;
              r_state  <= RUN;
            end
          end
        end
        RUN: begin
          r_remain <= r_remain - CYC_WIDTH'(1);
          if (r_cycles != {CYC_WIDTH{1'b1}}) r_cycles <= r_cycles + CYC_WIDTH'(1);
          if (r_remain == CYC_WIDTH'(1)) r_state <= DUMP;
        end
        DUMP: begin
          if (w_restart) begin
            r_state    <= LOAD;
            r_addr     <= '0;
            r_cycles   <= '0;
            r_overflow <= 1'b0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clock_in) begin
    if (!reset_in || w_restart) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + load_data_in;
    end
  end

  assign checksum_out = r_checksum;
`else
  assign checksum_out = '0;
`endif

  assign load_ready_out        = (r_state == LOAD);
  assign core_reset_out        = (r_state == RUN);
  assign done_out              = (r_state == DUMP);
  assign state_out             = r_state;
  assign instrWrite_out        = r_instr_we;
  assign instr_address_out     = r_instr_addr;
  assign instr_out             = r_instr;
  assign read_data_address_out = w_rd_addr;
  assign rd_valid_out          = r_rd_valid;
  assign rd_data_out           = r_rd_data;
  assign overflow_out          = r_overflow;
  assign cycle_count_out       = r_cycles;

endmodule
`default_nettype wire

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction/data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: instruction/readback word-address width.
REQ-003 SHALL have parameter NUM_CH, default 2: readback channel count, at least 1.
REQ-004 SHALL have parameter CYC_WIDTH, default 16: run-cycle counter width.
REQ-005 clock_in  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_in  in  1  synchronous, active-low reset.
REQ-007 load_valid_in / load_ready_out / load_data_in / load_last_in  in/out/in/in  1/1/DATA_WIDTH/1  program word stream, valid/ready handshake.
REQ-008 start_in, restart_in  in  1 each  begin run; return to load.
REQ-009 run_cycles_in  in  CYC_WIDTH  core cycles to execute.
REQ-010 core_reset_out  out  1  active-low reset to core.
REQ-011 instrWrite_out, instr_address_out, instr_out  out  1/ADDR_WIDTH/DATA_WIDTH  core instruction-memory write port.
REQ-012 read_data_address_out  out  ADDR_WIDTH / read_data_in  in  DATA_WIDTH  core data-memory read port, combinational read.
REQ-013 rd_req_in  in  NUM_CH / rd_addr_in  in  NUM_CH*ADDR_WIDTH  per-channel readback requests.
REQ-014 rd_valid_out  out  NUM_CH / rd_data_out  out  DATA_WIDTH  readback response.
REQ-015 state_out  out  2, done_out  out  1, overflow_out  out  1, cycle_count_out  out  CYC_WIDTH, checksum_out  out  DATA_WIDTH  status.

Function
REQ-016 FSM states SHALL be LOAD, WAIT, RUN, DUMP; state_out reports encoding.
REQ-017 LOAD: load_ready_out=1; each accepted word SHALL register instrWrite_out=1, instr_out=word, instr_address_out=current address on the next cycle; address increments by 1 from 0.
REQ-018 Word accepted with load_last_in=1 SHALL move FSM to WAIT.
REQ-019 Word accepted at address 2^ADDR_WIDTH-1 SHALL move to WAIT; overflow_out set sticky if load_last_in=0.
REQ-020 WAIT: core_reset_out=0; start_in=1 loads counter with run_cycles_in and moves to RUN; run_cycles_in=0 moves directly to DUMP.
REQ-021 RUN: core_reset_out=1 for exactly run_cycles_in cycles, then DUMP; cycle_count_out increments once per RUN cycle, saturating.
REQ-022 DUMP: core_reset_out=0, done_out=1; data memory not cleared by core reset.
REQ-023 DUMP: round-robin grant of one requesting channel per cycle, priority starting one above last grant; read_data_address_out = granted rd_addr_in slice.
REQ-024 Granted channel SHALL see rd_valid_out bit pulse one cycle after grant with rd_data_out = read_data_in captured at grant; all other bits 0.
REQ-025 rd_req_in outside DUMP SHALL be ignored; no grants, rd_valid_out=0.
REQ-026 restart_in in DUMP SHALL return to LOAD, address 0, clear cycle_count_out, overflow_out, checksum_out; restart wins over simultaneous read grant; in-flight response still delivered.
REQ-027 start_in outside WAIT and restart_in outside DUMP SHALL be ignored; load_ready_out=0 outside LOAD.

Reset
REQ-028 reset_in=0 at clock edge SHALL force LOAD, address 0, pointer to channel 0; outputs: load_ready_out=1, core_reset_out=0, instrWrite_out=0, rd_valid_out=0, done_out=0, overflow_out=0, counts/checksum/addresses/data 0.
REQ-029 Reset mid-operation (any state) SHALL abandon pending writes and reads without output pulses.

Configuration
REQ-030 With MIPS_LOADER_CHECKSUM_EN defined, checksum_out SHALL be the sum modulo 2^DATA_WIDTH of all words accepted since reset/restart, updated the cycle after acceptance; undefined, checksum_out constant 0.

Structure
REQ-031 Package mips_loader_pkg SHALL hold loader_state_t enum (LOAD=0, WAIT=1, RUN=2, DUMP=3) and default parameter constants.
REQ-032 Round-robin arbitration SHALL be sub-module mips_rr_arbiter (parametrised by NUM_CH, one-hot grant).

Verification
REQ-033 Load 3 words 0x20080005, 0x21090003, 0xAC090000, last on third -> write pulses at addresses 0,1,2; state WAIT; overflow 0.
REQ-034 run_cycles_in=10, start -> core_reset_out high exactly 10 cycles, cycle_count_out=10, done_out=1.
REQ-035 NUM_CH=2, both request addr 0 and 1 same cycle in DUMP -> ch0 valid then ch1 valid, consecutive cycles, data equal to memory words.
REQ-036 ADDR_WIDTH=2, 4 words no last -> WAIT after 4th, overflow_out=1; run_cycles_in=0 start -> DUMP next cycle.
REQ-037 reset_in=0 during RUN cycle 4 -> next cycle LOAD, core_reset_out=0, counts 0; with checksum macro, words 1,2,3 -> checksum_out=6.
